// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory's single access port between the core
// load/store unit (c_) and a DMA/debug master (d_). Each granted request runs
// IDLE -> ISSUE -> WAIT -> RESP and completes with a one-cycle ack pulse.
// Optional feature macro: DMEM_ARB_RR_EN selects round-robin tie breaking;
// without it the core always wins a tie.
module dmem_arbiter #(
  parameter int AW_WORDS = 9
) (
  input  logic        clkd,
  input  logic        rst_n,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [1:0]  c_size,
  input  logic        c_uns,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_ack,
  output logic [31:0] c_rdata,
  output logic        c_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_uns,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] aluout,
  output logic [31:0] rs2_out,
  output logic        dmem_sel,
  output logic [2:0]  L_inst,
  output logic [1:0]  S_inst,
  input  logic [31:0] dmem_out,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [2:0] L_NOP = 3'b111;
  localparam logic [1:0] S_NOP = 2'b11;

  state_t      r_state;
  logic        r_gnt_d;     // 1 = DMA port owns the current transaction
  logic        r_err;
  logic        r_load_ok;   // good load: return dmem_out at end of WAIT
  logic        r_c_ack, r_d_ack, r_c_err, r_d_err;
  logic [31:0] r_c_rdata, r_d_rdata;
  logic [31:0] r_aluout, r_rs2;
  logic        r_sel;
  logic [2:0]  r_linst;
  logic [1:0]  r_sinst;
  logic        r_busy;
`ifdef DMEM_ARB_RR_EN
  logic        r_last_grant; // 1 = DMA was granted last
`endif

  logic        w_any;
  logic        w_pick_d;
  logic        w_we;
  logic [1:0]  w_size;
  logic        w_uns;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_err;
  logic [2:0]  w_linst;

  assign w_any = c_req | d_req;

`ifdef DMEM_ARB_RR_EN
  // On a tie the port that did not win last time goes first.
  assign w_pick_d = d_req & (~c_req | ~r_last_grant);
`else
  // Core has fixed priority on a tie.
  assign w_pick_d = d_req & ~c_req;
`endif

  assign w_we    = w_pick_d ? d_we    : c_we;
  assign w_size  = w_pick_d ? d_size  : c_size;
  assign w_uns   = w_pick_d ? d_uns   : c_uns;
  assign w_addr  = w_pick_d ? d_addr  : c_addr;
  assign w_wdata = w_pick_d ? d_wdata : c_wdata;

  // Bad address (beyond memory depth) or the reserved size code.
  assign w_err = ((w_addr >> AW_WORDS) != 32'd0) || (w_size == 2'b11);

  // Load encoding: bit 2 marks unsigned, low bits carry the access size.
  always_comb begin
    w_linst = L_NOP;
    case (w_size)
      2'b00:   w_linst = 3'b000;
      2'b01:   w_linst = {w_uns, 2'b01};
      2'b10:   w_linst = {w_uns, 2'b10};
      default: w_linst = L_NOP;
    endcase
  end

  // Transaction sequencer; every output is a register updated here.
  always_ff @(posedge clkd or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_gnt_d   <= 1'b0;
      r_err     <= 1'b0;
      r_load_ok <= 1'b0;
      r_c_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_c_err   <= 1'b0;
      r_d_err   <= 1'b0;
      r_c_rdata <= 32'd0;
      r_d_rdata <= 32'd0;
      r_aluout  <= 32'd0;
      r_rs2     <= 32'd0;
      r_sel     <= 1'b0;
      r_linst   <= L_NOP;
      r_sinst   <= S_NOP;
      r_busy    <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state   <= S_ISSUE;
            r_busy    <= 1'b1;
            r_gnt_d   <= w_pick_d;
            r_err     <= w_err;
            r_load_ok <= ~w_we & ~w_err;
`ifdef DMEM_ARB_RR_EN
            r_last_grant <= w_pick_d;
`endif
            if (w_err) begin
              // Present a no-op so memory is never touched.
              r_sel    <= 1'b0;
              r_linst  <= L_NOP;
              r_sinst  <= S_NOP;
              r_aluout <= 32'd0;
            end else if (w_we) begin
              r_sel    <= 1'b1;
              r_linst  <= L_NOP;
              r_sinst  <= w_size;
              r_aluout <= w_addr;
              r_rs2    <= w_wdata;
            end else begin
              r_sel    <= 1'b0;
              r_linst  <= w_linst;
              r_sinst  <= S_NOP;
              r_aluout <= w_addr;
            end
          end
        end
        S_ISSUE: begin
          // Memory acts on this edge; drop its controls back to idle.
          r_state <= S_WAIT;
          r_sel   <= 1'b0;
          r_linst <= L_NOP;
          r_sinst <= S_NOP;
        end
        S_WAIT: begin
          r_state <= S_RESP;
          if (r_gnt_d) begin
            r_d_ack   <= 1'b1;
            r_d_err   <= r_err;
            r_d_rdata <= r_load_ok ? dmem_out : 32'd0;
          end else begin
            r_c_ack   <= 1'b1;
            r_c_err   <= r_err;
            r_c_rdata <= r_load_ok ? dmem_out : 32'd0;
          end
        end
        S_RESP: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_c_ack   <= 1'b0;
          r_d_ack   <= 1'b0;
          r_c_err   <= 1'b0;
          r_d_err   <= 1'b0;
          r_c_rdata <= 32'd0;
          r_d_rdata <= 32'd0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign c_ack    = r_c_ack;
  assign d_ack    = r_d_ack;
  assign c_err    = r_c_err;
  assign d_err    = r_d_err;
  assign c_rdata  = r_c_rdata;
  assign d_rdata  = r_d_rdata;
  assign aluout   = r_aluout;
  assign rs2_out  = r_rs2;
  assign dmem_sel = r_sel;
  assign L_inst   = r_linst;
  assign S_inst   = r_sinst;
  assign busy     = r_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural data memory plus a transaction-level
// reference model (word array, arbitration rule, extension arithmetic).
module tb_dmem_arbiter;
  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;

  logic clkd  = 1'b0;
  logic rst_n = 1'b1;
  always #5 clkd = ~clkd;

  // Index 0 = core port, 1 = DMA port.
  logic        p_req   [2];
  logic        p_we    [2];
  logic [1:0]  p_size  [2];
  logic        p_uns   [2];
  logic [31:0] p_addr  [2];
  logic [31:0] p_wdata [2];

  logic        c_ack, d_ack, c_err, d_err, dmem_sel, busy;
  logic [31:0] c_rdata, d_rdata, aluout, rs2_out, dmem_out;
  logic [2:0]  L_inst;
  logic [1:0]  S_inst;

  dmem_arbiter #(.AW_WORDS(AW)) dut (
    .clkd(clkd), .rst_n(rst_n),
    .c_req(p_req[0]), .c_we(p_we[0]), .c_size(p_size[0]), .c_uns(p_uns[0]),
    .c_addr(p_addr[0]), .c_wdata(p_wdata[0]),
    .c_ack(c_ack), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(p_req[1]), .d_we(p_we[1]), .d_size(p_size[1]), .d_uns(p_uns[1]),
    .d_addr(p_addr[1]), .d_wdata(p_wdata[1]),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .aluout(aluout), .rs2_out(rs2_out), .dmem_sel(dmem_sel),
    .L_inst(L_inst), .S_inst(S_inst), .dmem_out(dmem_out), .busy(busy)
  );

  // Behavioural data memory: acts on the controls at each rising edge.
  logic [31:0] mem [DEPTH];
  always @(posedge clkd) begin
    if (dmem_sel) begin
      case (S_inst)
        2'b00:   mem[aluout[AW-1:0]]       <= rs2_out;
        2'b01:   mem[aluout[AW-1:0]][7:0]  <= rs2_out[7:0];
        2'b10:   mem[aluout[AW-1:0]][15:0] <= rs2_out[15:0];
        default: ;
      endcase
    end
    case (L_inst)
      3'b000: dmem_out <= mem[aluout[AW-1:0]];
      3'b001: dmem_out <= {{24{mem[aluout[AW-1:0]][7]}}, mem[aluout[AW-1:0]][7:0]};
      3'b010: dmem_out <= {{16{mem[aluout[AW-1:0]][15]}}, mem[aluout[AW-1:0]][15:0]};
      3'b101: dmem_out <= {24'd0, mem[aluout[AW-1:0]][7:0]};
      3'b110: dmem_out <= {16'd0, mem[aluout[AW-1:0]][15:0]};
      default: ;
    endcase
  end

  // Reference model state.
  logic [31:0] ref_mem [DEPTH];
  int          ref_last;   // 1 = DMA granted last
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_txn    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] size, input logic uns);
    logic [31:0] v;
    if (size == 2'd1) begin
      v = w % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 2'd2) begin
      v = w % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic set_req(input int p, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    p_we[p] = we; p_size[p] = size; p_uns[p] = uns;
    p_addr[p] = addr; p_wdata[p] = wdata; p_req[p] = 1'b1;
  endtask

  // Runs one transaction from a negedge with at least one request pending.
  task automatic txn();
    int          w, a;
    logic        e;
    logic [31:0] exp_rd;
    logic [1:0]  exp_acks;
    if (p_req[0] && p_req[1]) begin
`ifdef DMEM_ARB_RR_EN
      w = (ref_last == 1) ? 0 : 1;
`else
      w = 0;
`endif
    end else begin
      w = p_req[0] ? 0 : 1;
    end
    ref_last = w;
    a = int'(p_addr[w] % DEPTH);
    e = (p_addr[w] >= DEPTH) || (p_size[w] == 2'b11);
    exp_rd = (!e && !p_we[w]) ? ref_load(ref_mem[a], p_size[w], p_uns[w]) : 32'd0;
    exp_acks = (w == 0) ? 2'b10 : 2'b01;

    @(posedge clkd); @(negedge clkd);           // after E0: ISSUE
    check("busy_issue", busy, 1);
    check("ack_issue", {c_ack, d_ack}, 0);
    check("sel_issue", dmem_sel, p_we[w] && !e);
    check("aluout_issue", aluout, e ? 32'd0 : p_addr[w]);
    @(posedge clkd); @(negedge clkd);           // after E1: WAIT
    check("ack_wait", {c_ack, d_ack}, 0);
    check("sel_wait", dmem_sel, 0);
    check("linst_wait", L_inst, 3'b111);
    check("sinst_wait", S_inst, 2'b11);
    @(posedge clkd); @(negedge clkd);           // after E2: RESP
    check("ack_resp", {c_ack, d_ack}, exp_acks);
    check("rdata", (w == 0) ? c_rdata : d_rdata, exp_rd);
    check("err", (w == 0) ? c_err : d_err, e);
    check("other_rdata", (w == 0) ? d_rdata : c_rdata, 0);
    check("other_err", (w == 0) ? d_err : c_err, 0);
    $display("txn %0d: port=%s we=%0d size=%0d uns=%0d addr=%h wdata=%h rdata=%h err=%0d",
             n_txn, (w == 0) ? "core" : "dma", p_we[w], p_size[w], p_uns[w], p_addr[w],
             p_wdata[w], (w == 0) ? c_rdata : d_rdata, (w == 0) ? c_err : d_err);
    n_txn++;
    if (!e && p_we[w]) begin
      if (p_size[w] == 2'd0)      ref_mem[a] = p_wdata[w];
      else if (p_size[w] == 2'd1) ref_mem[a] = (ref_mem[a] & ~32'hFF)   | (p_wdata[w] & 32'hFF);
      else                        ref_mem[a] = (ref_mem[a] & ~32'hFFFF) | (p_wdata[w] & 32'hFFFF);
    end
    p_req[w] = 1'b0;
    @(posedge clkd); @(negedge clkd);           // after E3: IDLE
    check("ack_clear", {c_ack, d_ack}, 0);
    check("busy_clear", busy, 0);
  endtask

  task automatic idle_cycle();
    @(posedge clkd); @(negedge clkd);
    check("busy_idle", busy, 0);
    check("ack_idle", {c_ack, d_ack}, 0);
  endtask

  task automatic rand_req(input int p);
    logic [31:0] addr;
    int          s;
    addr = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h200) : 32'($urandom_range(0, 15));
    s = $urandom_range(0, 9);
    set_req(p, 1'($urandom_range(0, 1)), (s < 8) ? 2'(s % 3) : 2'b11,
            1'($urandom_range(0, 1)), addr, $urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    for (int p = 0; p < 2; p++) begin
      p_req[p] = 0; p_we[p] = 0; p_size[p] = 0; p_uns[p] = 0; p_addr[p] = 0; p_wdata[p] = 0;
    end
    ref_last = 1;
    #1 rst_n = 1'b0;
    @(negedge clkd); @(negedge clkd);
    check("rst_acks", {c_ack, d_ack}, 0);
    check("rst_errs", {c_err, d_err}, 0);
    check("rst_c_rdata", c_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_aluout", aluout, 0);
    check("rst_rs2", rs2_out, 0);
    check("rst_sel", dmem_sel, 0);
    check("rst_linst", L_inst, 3'b111);
    check("rst_sinst", S_inst, 2'b11);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle_cycle();

    // Core store then load.
    set_req(0, 1, 2'd0, 0, 32'd5, 32'hDEADBEEF); txn();
    set_req(0, 0, 2'd0, 0, 32'd5, 32'd0);        txn();

    // Sub-word loads of 0x000080F0.
    set_req(0, 1, 2'd0, 0, 32'd3, 32'h000080F0); txn();
    set_req(0, 0, 2'd1, 0, 32'd3, 32'd0); txn();
    set_req(0, 0, 2'd1, 1, 32'd3, 32'd0); txn();
    set_req(0, 0, 2'd2, 0, 32'd3, 32'd0); txn();
    set_req(0, 0, 2'd2, 1, 32'd3, 32'd0); txn();

    // Tie: both held high for three transactions, then drain.
    for (int i = 0; i < 3; i++) begin
      if (!p_req[0]) set_req(0, 0, 2'd0, 0, 32'd5, 32'd0);
      if (!p_req[1]) set_req(1, 0, 2'd0, 0, 32'd3, 32'd0);
      txn();
    end
    while (p_req[0] || p_req[1]) txn();

    // Errors: out-of-range DMA store, then addr 0 untouched, then size 11.
    set_req(1, 1, 2'd0, 0, 32'h200, 32'h12345678); txn();
    set_req(0, 0, 2'd0, 0, 32'd0, 32'd0);          txn();
    set_req(0, 0, 2'b11, 0, 32'd7, 32'd0);         txn();

    // Reset during ISSUE of a store to addr 6.
    set_req(0, 1, 2'd0, 0, 32'd6, 32'hCAFEF00D);
    @(posedge clkd);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_acks", {c_ack, d_ack}, 0);
    check("midrst_sel", dmem_sel, 0);
    check("midrst_linst", L_inst, 3'b111);
    check("midrst_sinst", S_inst, 2'b11);
    check("midrst_aluout", aluout, 0);
    check("midrst_rs2", rs2_out, 0);
    p_req[0] = 1'b0;
    ref_last = 1;
    @(negedge clkd); @(posedge clkd); @(negedge clkd);
    check("midrst_noack", {c_ack, d_ack}, 0);
    rst_n = 1'b1;
    set_req(0, 0, 2'd0, 0, 32'd6, 32'd0); txn();

    // Back-to-back core requests.
    for (int i = 0; i < 4; i++) begin
      rand_req(0);
      txn();
    end

    // Randomized traffic on both ports.
    for (int i = 0; i < 150; i++) begin
      for (int p = 0; p < 2; p++)
        if (!p_req[p] && $urandom_range(0, 2) != 0) rand_req(p);
      if (p_req[0] || p_req[1]) txn();
      else idle_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
